// File: rtl/uart_rx.sv
// UART receive front end: 16x oversampled 8N1 deserializer with 3-sample majority vote,
// valid/ready output stage and pulsed framing/overrun error flags.
module uart_rx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_16x_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned TCNT_W = 4;
  localparam int unsigned BCNT_W = $clog2(DATA_BITS);
  localparam logic [TCNT_W-1:0] T_SAMP0  = TCNT_W'(7);
  localparam logic [TCNT_W-1:0] T_SAMP1  = TCNT_W'(8);
  localparam logic [TCNT_W-1:0] T_DECIDE = TCNT_W'(9);
  localparam logic [TCNT_W-1:0] T_LAST   = TCNT_W'(15);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TCNT_W-1:0]    tcnt;
  logic [BCNT_W-1:0]    bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp0;
  logic                 samp1;
  logic                 maj_c;

  // Two-flop synchronizer, idle-high reset so no false start after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Majority of the samples at tcnt 7 and 8 and the live sample at tcnt 9
  always_comb begin
    maj_c = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      samp0       <= 1'b1;
      samp1       <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;

      // Handshake path is independent of the tick path; a load below overrides it
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (baud_16x_tick) begin
        if (tcnt == T_SAMP0) samp0 <= rx_s;
        if (tcnt == T_SAMP1) samp1 <= rx_s;

        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              tcnt  <= TCNT_W'(1);
            end
          end

          START: begin
            if (tcnt == T_DECIDE && maj_c) begin
              state <= IDLE;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
              if (tcnt == T_LAST) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
          end

          DATA: begin
            tcnt <= tcnt + TCNT_W'(1);
            if (tcnt == T_DECIDE) begin
              shreg <= {maj_c, shreg[DATA_BITS-1:1]};
            end
            if (tcnt == T_LAST) begin
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + BCNT_W'(1);
              end
            end
          end

          STOP: begin
            if (tcnt == T_DECIDE) begin
              tcnt <= '0;
              if (maj_c) begin
                // Leave early so the next start edge is caught with margin
                state <= IDLE;
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun_err <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              tcnt <= tcnt + TCNT_W'(1);
            end
          end

          WAIT_HIGH: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule
